// File: rtl/ntsc_line_fetch_if.sv
// Word-read bus between the line fetch stage and main memory.
// Master holds req/addr until ack; data is valid with ack.
interface ntsc_line_fetch_if;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data
    );
endinterface

// File: rtl/ntsc_line_fetch.sv
// Framebuffer line fetch: prefetches the next 2 bpp scanline into a
// ping-pong buffer and serves pixel levels to the NTSC generator.
module ntsc_line_fetch #(
    parameter logic [15:0] FB_BASE        = 16'h8000,
    parameter int          WORDS_PER_LINE = 32,
    parameter int          LINES          = 256,
    parameter int          LAST_LINE      = 311
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    input  logic [9:0]         xpos,
    input  logic [8:0]         ypos,
    output logic [1:0]         pix_data,
    output logic               underrun,
    ntsc_line_fetch_if.master  mem
);
    localparam int              WW     = $clog2(WORDS_PER_LINE);
    localparam logic [15:0]     WPL    = 16'(WORDS_PER_LINE);
    localparam logic [WW-1:0]   LAST_W = WW'(WORDS_PER_LINE - 1);
    localparam logic [9:0]      X_END  = 10'(16 * WORDS_PER_LINE);

    typedef enum logic {IDLE, REQ} state_t;

    state_t        state, state_nx;
    logic [15:0]   lbuf [2][WORDS_PER_LINE];
    logic [1:0]    valid;
    logic [8:0]    line, pend_line, tgt, rs_line;
    logic [WW-1:0] word;
    logic          pend, fetch, last, restart;
    logic [WW-1:0] rd_idx;
    logic [2:0]    rd_p;
    logic [15:0]   rd_w;
    logic          active;

    function automatic logic [15:0] addr_of(input logic [8:0] l,
                                            input logic [WW-1:0] w);
        return FB_BASE + {7'd0, l} * WPL + {{(16-WW){1'b0}}, w};
    endfunction

    always_comb begin
        fetch = 1'b0;
        tgt   = '0;
        if (pix_ce && xpos == 10'd0) begin
            if (ypos < 9'(LINES - 1)) begin
                fetch = 1'b1;
                tgt   = ypos + 9'd1;
            end else if (ypos == 9'(LAST_LINE)) begin
                fetch = 1'b1;
            end
        end
        last    = (word == LAST_W);
        restart = pend | fetch;
        rs_line = fetch ? tgt : pend_line;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (fetch) state_nx = REQ;
            REQ:  if (mem.mem_ack && last && !restart) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign mem.mem_req = (state == REQ);

    // A trigger mid-fetch is latched in pend and taken after the in-flight ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line         <= '0;
            pend_line    <= '0;
            word         <= '0;
            pend         <= 1'b0;
            valid        <= '0;
            underrun     <= 1'b0;
            mem.mem_addr <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (fetch) begin
                        valid[tgt[0]] <= 1'b0;
                        line          <= tgt;
                        word          <= '0;
                        mem.mem_addr  <= addr_of(tgt, '0);
                    end
                end
                REQ: begin
                    if (fetch) begin
                        underrun      <= 1'b1;
                        valid[tgt[0]] <= 1'b0;
                        pend          <= 1'b1;
                        pend_line     <= tgt;
                    end
                    if (mem.mem_ack) begin
                        if (restart) begin
                            pend         <= 1'b0;
                            line         <= rs_line;
                            word         <= '0;
                            mem.mem_addr <= addr_of(rs_line, '0);
                        end else if (last) begin
                            valid[line[0]] <= 1'b1;
                        end else begin
                            word         <= word + 1'b1;
                            mem.mem_addr <= addr_of(line, word + 1'b1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == REQ && mem.mem_ack)
            lbuf[line[0]][word] <= mem.mem_data;
    end

    always_comb begin
        rd_idx = xpos[WW+3:4];
        rd_p   = xpos[3:1];
        rd_w   = lbuf[ypos[0]][rd_idx];
        active = (xpos < X_END) && (ypos < 9'(LINES)) && valid[ypos[0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pix_data <= '0;
        else if (pix_ce)
            pix_data <= active ? rd_w[{~rd_p, 1'b1} -: 2] : 2'd0;
    end
endmodule

// File: tb/tb_ntsc_line_fetch.sv
// Scoreboard bench: two fetch stages (default base and wrapping base)
// share the generator stimulus; each has its own memory model.
module tb_ntsc_line_fetch;
    localparam int BASE1 = 32'h8000;
    localparam int BASE2 = 32'hFFF0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_ce = 1'b0;
    logic [9:0] xpos = '0;
    logic [8:0] ypos = '0;
    logic [1:0] pix1, pix2;
    logic       und1, und2;

    ntsc_line_fetch_if mif1();
    ntsc_line_fetch_if mif2();

    ntsc_line_fetch dut1 (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .xpos(xpos),
        .ypos(ypos), .pix_data(pix1), .underrun(und1), .mem(mif1)
    );

    ntsc_line_fetch #(.FB_BASE(16'hFFF0)) dut2 (
        .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .xpos(xpos),
        .ypos(ypos), .pix_data(pix2), .underrun(und2), .mem(mif2)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          wait1 = 0;
    int          cnt1 = 0;
    logic [15:0] q1[$];
    logic [15:0] q2[$];
    logic [15:0] ack_addr1, ack_addr2, prev_addr1, prev_addr2, e1, e2;
    logic        prev_req1 = 1'b0;
    logic        prev_req2 = 1'b0;
    bit          exp_under1 = 1'b0;
    bit          exp_under2 = 1'b0;

    // memory model 1: ack after wait1 idle request cycles, data = address
    always @(negedge clk) begin
        if (rst_n && mif1.mem_ack === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                failures++;
                $display("FAIL dut1_unexpected_fetch got=%h required=none", ack_addr1);
            end else begin
                e1 = q1.pop_front();
                if (ack_addr1 !== e1) begin
                    failures++;
                    $display("FAIL dut1_fetch_addr got=%h required=%h", ack_addr1, e1);
                end
            end
        end
        if (rst_n && prev_req1 && mif1.mem_ack !== 1'b1) begin
            checks++;
            if (mif1.mem_req !== 1'b1 || mif1.mem_addr !== prev_addr1) begin
                failures++;
                $display("FAIL dut1_req_hold got=%b/%h required=1/%h",
                         mif1.mem_req, mif1.mem_addr, prev_addr1);
            end
        end
        prev_req1  = rst_n && (mif1.mem_req === 1'b1);
        prev_addr1 = mif1.mem_addr;
        if (!rst_n || mif1.mem_req !== 1'b1) begin
            mif1.mem_ack = 1'b0;
            cnt1 = 0;
        end else if (cnt1 >= wait1) begin
            mif1.mem_ack  = 1'b1;
            mif1.mem_data = mif1.mem_addr;
            ack_addr1     = mif1.mem_addr;
            cnt1 = 0;
        end else begin
            mif1.mem_ack = 1'b0;
            cnt1++;
        end
    end

    // memory model 2: zero wait states
    always @(negedge clk) begin
        if (rst_n && mif2.mem_ack === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                failures++;
                $display("FAIL dut2_unexpected_fetch got=%h required=none", ack_addr2);
            end else begin
                e2 = q2.pop_front();
                if (ack_addr2 !== e2) begin
                    failures++;
                    $display("FAIL dut2_fetch_addr got=%h required=%h", ack_addr2, e2);
                end
            end
        end
        if (rst_n && prev_req2 && mif2.mem_ack !== 1'b1) begin
            checks++;
            if (mif2.mem_req !== 1'b1 || mif2.mem_addr !== prev_addr2) begin
                failures++;
                $display("FAIL dut2_req_hold got=%b/%h required=1/%h",
                         mif2.mem_req, mif2.mem_addr, prev_addr2);
            end
        end
        prev_req2  = rst_n && (mif2.mem_req === 1'b1);
        prev_addr2 = mif2.mem_addr;
        if (!rst_n || mif2.mem_req !== 1'b1) begin
            mif2.mem_ack = 1'b0;
        end else begin
            mif2.mem_ack  = 1'b1;
            mif2.mem_data = mif2.mem_addr;
            ack_addr2     = mif2.mem_addr;
        end
    end

    function automatic logic [1:0] exp_pix(input int base, input int x,
                                           input int y, input bit vld);
        logic [15:0] a;
        int p;
        if (!vld || x >= 512 || y >= 256) return 2'd0;
        a = 16'(base + y * 32 + x / 16);
        p = (x / 2) % 8;
        return 2'((a >> (14 - 2 * p)) & 16'd3);
    endfunction

    task automatic model_trigger(input int t);
        if (q1.size() != 0) begin
            exp_under1 = 1'b1;
            while (q1.size() > 1) void'(q1.pop_back());
        end
        if (q2.size() != 0) begin
            exp_under2 = 1'b1;
            while (q2.size() > 1) void'(q2.pop_back());
        end
        for (int w = 0; w < 32; w++) begin
            q1.push_back(16'(BASE1 + t * 32 + w));
            q2.push_back(16'(BASE2 + t * 32 + w));
        end
    endtask

    task automatic drive_pix(input int x, input int y);
        @(negedge clk); #1;
        if (x == 0 && y < 255) model_trigger(y + 1);
        else if (x == 0 && y == 311) model_trigger(0);
        pix_ce = 1'b1;
        xpos = 10'(x);
        ypos = 9'(y);
        @(negedge clk); #1;
        pix_ce = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (q1.size() != 0 || q2.size() != 0) begin
            failures++;
            $display("FAIL fetch_timeout got=%0d/%0d words left required=0/0",
                     q1.size(), q2.size());
        end
        checks++;
        if (mif1.mem_req !== 1'b0 || mif2.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL req_drop got=%b/%b required=0/0", mif1.mem_req, mif2.mem_req);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({pix1, mif1.mem_req, mif1.mem_addr, und1} !== 20'd0) begin
            failures++;
            $display("FAIL reset_dut1 got=%h required=0",
                     {pix1, mif1.mem_req, mif1.mem_addr, und1});
        end
        checks++;
        if ({pix2, mif2.mem_req, mif2.mem_addr, und2} !== 20'd0) begin
            failures++;
            $display("FAIL reset_dut2 got=%h required=0",
                     {pix2, mif2.mem_req, mif2.mem_addr, und2});
        end
        rst_n = 1'b1;
        drive_pix(1, 0);
        checks++;
        if (pix1 !== 2'd0 || pix2 !== 2'd0) begin
            failures++;
            $display("FAIL reset_invalid_bank got=%0d/%0d required=0/0", pix1, pix2);
        end
    endtask

    task automatic test_first_frame;
        int xs[4] = '{240, 254, 256, 510};
        wait1 = 0;
        drive_pix(0, 311);
        checks++;
        if (pix1 !== 2'd0) begin
            failures++;
            $display("FAIL frame_trigger_pix got=%0d required=0", pix1);
        end
        drain(200);
        for (int x = 0; x < 16; x++) begin
            drive_pix(x, 0);
            checks++;
            if (pix1 !== exp_pix(BASE1, x, 0, 1'b1)) begin
                failures++;
                $display("FAIL line0_pix x=%0d got=%0d required=%0d",
                         x, pix1, exp_pix(BASE1, x, 0, 1'b1));
            end
            checks++;
            if (pix2 !== exp_pix(BASE2, x, 0, 1'b1)) begin
                failures++;
                $display("FAIL wrap_pix x=%0d got=%0d required=%0d",
                         x, pix2, exp_pix(BASE2, x, 0, 1'b1));
            end
        end
        foreach (xs[i]) begin
            drive_pix(xs[i], 0);
            checks++;
            if (pix2 !== exp_pix(BASE2, xs[i], 0, 1'b1)) begin
                failures++;
                $display("FAIL wrap_pix x=%0d got=%0d required=%0d",
                         xs[i], pix2, exp_pix(BASE2, xs[i], 0, 1'b1));
            end
        end
        drain(200);
    endtask

    task automatic test_hold;
        logic [1:0] h = exp_pix(BASE1, 2, 0, 1'b1);
        drive_pix(2, 0);
        for (int i = 0; i < 3; i++) begin
            xpos = 10'(40 + i * 6);
            @(negedge clk); #1;
        end
        checks++;
        if (pix1 !== h) begin
            failures++;
            $display("FAIL pix_hold got=%0d required=%0d", pix1, h);
        end
    endtask

    task automatic test_steady_state;
        int xs[5] = '{0, 32, 100, 300, 511};
        drive_pix(0, 9);
        drain(200);
        foreach (xs[i]) begin
            drive_pix(xs[i], 10);
            checks++;
            if (pix1 !== exp_pix(BASE1, xs[i], 10, 1'b1)) begin
                failures++;
                $display("FAIL line10_pix x=%0d got=%0d required=%0d",
                         xs[i], pix1, exp_pix(BASE1, xs[i], 10, 1'b1));
            end
        end
        drain(200);
        checks++;
        if (und1 !== 1'b0 || und2 !== 1'b0) begin
            failures++;
            $display("FAIL steady_underrun got=%b/%b required=0/0", und1, und2);
        end
    endtask

    task automatic test_blanking;
        int xs[4] = '{512, 520, 600, 635};
        int ys[4] = '{255, 256, 300, 310};
        foreach (xs[i]) begin
            drive_pix(xs[i], 10);
            checks++;
            if (pix1 !== 2'd0 || pix2 !== 2'd0) begin
                failures++;
                $display("FAIL hblank x=%0d got=%0d/%0d required=0/0", xs[i], pix1, pix2);
            end
        end
        foreach (ys[i]) begin
            drive_pix(0, ys[i]);
            if (ys[i] != 255) begin
                checks++;
                if (pix1 !== 2'd0 || pix2 !== 2'd0) begin
                    failures++;
                    $display("FAIL vblank y=%0d got=%0d/%0d required=0/0",
                             ys[i], pix1, pix2);
                end
            end
        end
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (mif1.mem_req !== 1'b0 || mif2.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL blank_no_fetch got=%b/%b required=0/0", mif1.mem_req, mif2.mem_req);
        end
    endtask

    task automatic test_slow_memory;
        wait1 = 119;
        drive_pix(0, 20);
        repeat (500) @(negedge clk);
        #1;
        checks++;
        if (mif1.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL slow_in_fetch got=%b required=1", mif1.mem_req);
        end
        drive_pix(0, 21);
        checks++;
        if (und1 !== exp_under1 || und2 !== exp_under2 || mif1.mem_req !== 1'b1) begin
            failures++;
            $display("FAIL underrun_flag got=%b/%b/%b required=%b/%b/1",
                     und1, und2, mif1.mem_req, exp_under1, exp_under2);
        end
        drain(6000);
        drive_pix(100, 21);
        checks++;
        if (pix1 !== 2'd0 || pix2 !== exp_pix(BASE2, 100, 21, 1'b1)) begin
            failures++;
            $display("FAIL starved_line got=%0d/%0d required=0/%0d",
                     pix1, pix2, exp_pix(BASE2, 100, 21, 1'b1));
        end
        drive_pix(100, 22);
        checks++;
        if (pix1 !== exp_pix(BASE1, 100, 22, 1'b1)) begin
            failures++;
            $display("FAIL restarted_line got=%0d required=%0d",
                     pix1, exp_pix(BASE1, 100, 22, 1'b1));
        end
        checks++;
        if (und1 !== 1'b1 || und2 !== 1'b0) begin
            failures++;
            $display("FAIL underrun_sticky got=%b/%b required=1/0", und1, und2);
        end
    endtask

    task automatic test_reset_mid_fetch;
        wait1 = 100000;
        drive_pix(0, 22);
        checks++;
        if (pix1 !== exp_pix(BASE1, 0, 22, 1'b1)) begin
            failures++;
            $display("FAIL pre_reset_pix got=%0d required=%0d",
                     pix1, exp_pix(BASE1, 0, 22, 1'b1));
        end
        repeat (40) @(negedge clk);
        #1;
        checks++;
        if (mif1.mem_req !== 1'b1 || und1 !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset_state got=%b/%b required=1/1", mif1.mem_req, und1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pix1, mif1.mem_req, mif1.mem_addr, und1} !== 20'd0) begin
            failures++;
            $display("FAIL async_reset got=%h required=0",
                     {pix1, mif1.mem_req, mif1.mem_addr, und1});
        end
        q1.delete();
        exp_under1 = 1'b0;
        wait1 = 0;
        repeat (3) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (mif1.mem_req !== 1'b0 || mif2.mem_req !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_req got=%b/%b required=0/0", mif1.mem_req, mif2.mem_req);
        end
        drive_pix(100, 22);
        checks++;
        if (pix1 !== 2'd0 || pix2 !== 2'd0) begin
            failures++;
            $display("FAIL post_reset_valid got=%0d/%0d required=0/0", pix1, pix2);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_hold();
        test_steady_state();
        test_blanking();
        test_slow_memory();
        test_reset_mid_fetch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ntsc_line_fetch.md
# ntsc_line_fetch

Framebuffer fetch stage directly upstream of the NTSC composite generator. Reads one 256-pixel, 2 bpp greyscale scanline per video line from d16 main memory over a req/ack word bus into a ping-pong line buffer. Supplies the pixel level for each position the generator scans. Fetches are made one line ahead, so memory latency never stalls the video timing.

## Interface
- `FB_BASE`, default 16'h8000: word address of line 0, pixel 0.
- `WORDS_PER_LINE`, default 32: 16-bit words per scanline (8 px/word).
- `LINES`, default 256: displayed framebuffer lines.
- `LAST_LINE`, default 311: final `ypos` value of the generator frame.

Ports:
- `clk`  in  1  system clock (50 MHz).
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_ce`  in  1  one-cycle strobe; `xpos`/`ypos` are sampled only when it is high.
- `xpos`  in  10  generator horizontal position, 0..635.
- `ypos`  in  9  generator line, 0..`LAST_LINE`.
- `pix_data`  out  2  pixel level for the generator's data path.
- `mem_req`  out  1  word read request.
- `mem_addr`  out  16  word address, stable while `mem_req` is high.
- `mem_ack`  in  1  read complete; `mem_data` is valid in the same cycle.
- `mem_data`  in  16  read word.
- `underrun`  out  1  sticky; set when a fetch failed to complete in time.

## Operation
- **Line buffer:** 2 banks × `WORDS_PER_LINE` × 16 bits. Each bank has a valid bit.
  - Line y is displayed from bank y[0].
  - Buffer contents are not reset.
- **Fetch trigger:** `pix_ce && xpos==0`.
  - If `ypos < LINES-1`, target line is `ypos+1`.
  - If `ypos == LAST_LINE`, target line is 0.
  - Otherwise there is no fetch.
- **FSM states:**
  - IDLE: on trigger, clear the target bank's valid bit, load word counter = 0, go to REQ.
  - REQ: hold `mem_req`=1 with `mem_addr = FB_BASE + line*WORDS_PER_LINE + word` (16-bit modulo, wraps). On `mem_ack`, write `mem_data` to bank[word] and increment word.
    - After the last word: set the bank's valid bit, drop `mem_req` in the same edge, go to IDLE.
    - Otherwise, present the next address on the next cycle; `mem_req` stays high.
- **Handshake rules:**
  - `mem_req` is never withdrawn before `mem_ack`.
  - `mem_addr` never changes while a request is unacknowledged.
  - `mem_ack` while `mem_req`=0 is ignored.
- **Trigger while in REQ (underrun):**
  - Set `underrun`.
  - Finish the in-flight word; that word is written.
  - Abandon the remaining words; the old bank stays invalid.
  - On the cycle after that ack, restart at word 0 for the new target line. That bank's valid bit is cleared at the trigger.
- **Pixel select** (when `pix_ce`):
  - Pixel is active when `xpos < 2*8*WORDS_PER_LINE`, `ypos < LINES`, and bank `ypos[0]` is valid.
  - word = `xpos[8:4]`, p = `xpos[3:1]` (each pixel is 2 clocks wide).
  - `pix_data <= word[15-2p -: 2]`, MSB pixel first.
  - When not active, `pix_data <= 0`.
- `pix_data` holds its value between strobes.

## Timing
- Reset values: `pix_data`=0, `mem_req`=0, `mem_addr`=0, `underrun`=0, both valid bits=0, FSM=IDLE, word counter=0. Reset mid-fetch drops `mem_req` immediately.
- Pixel latency: `pix_data` reflects the `xpos`/`ypos` of a `pix_ce` cycle from the next clock edge.
- `mem_req` rises on the clock edge after the trigger.
  - Zero-wait memory (ack in the first req cycle): one word per clock, 32 words in 32 clocks.
  - The line budget is 636 × 5 = 3180 clocks.
- A write and a display read of the same bank never coincide by construction. Read-before-write is not required.
- `underrun` clears only on reset.

## Test plan
- **Reset:** assert `rst_n`=0 mid-REQ with `mem_req`=1. Required: `mem_req`, `mem_addr`, `pix_data`, `underrun` all 0 asynchronously; no ack is consumed.
- **First frame:** memory model with 0 wait states, `mem_data` = address. At `ypos`=311, `xpos`=0: 32 reads at 8000..801F.
  - At line 0, `xpos`=0..15 gives `pix_data` = the 2-bit fields of 8000 MSB-first: 2,0,0,0,0,0,0,0 each held 2 pixels.
- **Steady state:** during line 10 at `xpos`=0, the fetch addresses are 8000+11*32 = 8160..817F into bank 1. During line 10, `pix_data` comes from bank 0; `underrun` stays 0.
- **Blanking:**
  - `xpos` 512..635 → `pix_data`=0.
  - Lines 256..310 → `pix_data`=0.
  - No fetch is triggered on lines 255..310.
- **Slow memory:** ack every 120 clocks. Required: the trigger at the next line occurs mid-fetch, `underrun`=1, the in-flight ack completes, `mem_req` stays high, and the next address restarts at word 0 of the new line. The starved line outputs 0.
- **Address wrap:** `FB_BASE`=16'hFFF0, line 0 → addresses FFF0..FFFF then 0000..000F.
